// File: rtl/vedic_pkg.sv
// Shared constants and elaboration helpers for the Vedic multiply/MAC unit.
package vedic_pkg;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_MAC = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Four guard bits give headroom for sixteen full-scale accumulations.
  function automatic int unsigned acc_width_default(input int unsigned w);
    return 2 * w + 4;
  endfunction

  localparam int unsigned DEFAULT_ACC_WIDTH = acc_width_default(DEFAULT_WIDTH);

  // Operand width must split cleanly down to the 2x2 base case.
  function automatic bit params_legal(input int unsigned w, input int unsigned aw);
    return (w >= 2) && (w <= 16) && ((w & (w - 1)) == 0) && (aw >= 2 * w);
  endfunction

endpackage

// File: rtl/vedic_nxn.sv
// Recursive combinational Vedic multiplier: four N/2 sub-products, shifted and summed,
// bottoming out in a gate-level 2x2 cell.
module vedic_nxn
  import vedic_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  if (N == 1) begin : gen_base1
    assign p = {1'b0, a & b};
  end else if (N == 2) begin : gen_base2
    logic c1;
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = (a[1] & b[1]) & c1;
  end else begin : gen_rec
    localparam int unsigned H = N / 2;
    logic [N-1:0] q0, q1, q2, q3;

    vedic_nxn #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(q0));
    vedic_nxn #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(q1));
    vedic_nxn #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(q2));
    vedic_nxn #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(q3));

    assign p = {{N{1'b0}}, q0}
             + {{H{1'b0}}, q1, {H{1'b0}}}
             + {{H{1'b0}}, q2, {H{1'b0}}}
             + {q3, {N{1'b0}}};
  end

endmodule

// File: rtl/vedic_mac_pipe.sv
// Two-stage pipelined Vedic multiply / multiply-accumulate with valid/ready on both
// sides and a sticky accumulator overflow flag.
module vedic_mac_pipe
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned ACC_WIDTH = acc_width_default(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 mode,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow
);

  localparam int unsigned H = WIDTH / 2;

  if (!params_legal(WIDTH, ACC_WIDTH)) begin : gen_bad_params
    $error("vedic_mac_pipe: WIDTH must be a power of two in 2..16 and ACC_WIDTH >= 2*WIDTH");
  end

  // Stage 1 state
  logic                  s1_valid_q, s1_mode_q, s1_clr_q;
  logic [3:0][WIDTH-1:0] pp_d, pp_q;

  // Stage 2 / architectural state
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sticky_q, sticky_d;

  logic                 adv;
  logic [2*WIDTH-1:0]   product;
  logic [ACC_WIDTH-1:0] product_ext;
  logic [ACC_WIDTH:0]   acc_sum;

  // S2 may load when the sink has taken (or never had) the current result.
  assign adv      = ena & (~out_valid_q | out_ready);
  assign in_ready = ena & (~s1_valid_q | adv);

  vedic_nxn #(.N(H)) u_pp0 (.a(a[H-1:0]),     .b(b[H-1:0]),     .p(pp_d[0]));
  vedic_nxn #(.N(H)) u_pp1 (.a(a[WIDTH-1:H]), .b(b[H-1:0]),     .p(pp_d[1]));
  vedic_nxn #(.N(H)) u_pp2 (.a(a[H-1:0]),     .b(b[WIDTH-1:H]), .p(pp_d[2]));
  vedic_nxn #(.N(H)) u_pp3 (.a(a[WIDTH-1:H]), .b(b[WIDTH-1:H]), .p(pp_d[3]));

  // Stage 1 register: partial products and control captured on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_MUL;
      s1_clr_q   <= 1'b0;
      pp_q       <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= mode;
        s1_clr_q  <= acc_clr;
        pp_q      <= pp_d;
      end
    end
  end

  // Stage 2 datapath: recombine partial products and form the accumulate sum.
  always_comb begin
    product     = {{WIDTH{1'b0}}, pp_q[0]}
                + {{H{1'b0}}, pp_q[1], {H{1'b0}}}
                + {{H{1'b0}}, pp_q[2], {H{1'b0}}}
                + {pp_q[3], {WIDTH{1'b0}}};
    product_ext = ACC_WIDTH'(product);
    acc_sum     = {1'b0, acc_q} + {1'b0, product_ext};
  end

  // Stage 2 next-state: result, accumulator and sticky overflow update.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    if (adv) begin
      if (s1_valid_q) begin
        out_valid_d = 1'b1;
        if (s1_mode_q == MODE_MAC) begin
          if (s1_clr_q) begin
            acc_d    = product_ext;
            sticky_d = 1'b0;
          end else begin
            acc_d    = acc_sum[ACC_WIDTH-1:0];
            sticky_d = sticky_q | acc_sum[ACC_WIDTH];
          end
          result_d = acc_d;
          ovf_d    = sticky_d;
        end else begin
          // Plain multiply leaves the accumulator alone but still reports its flag.
          result_d = product_ext;
          ovf_d    = sticky_q;
        end
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_vedic_mac_pipe.sv
// Scoreboard bench for vedic_mac_pipe at WIDTH=8, ACC_WIDTH=20.
module tb_vedic_mac_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          mode = 1'b0;
  logic          acc_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] result;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int pops = 0;

  typedef struct packed {
    logic [AW-1:0] res;
    logic          ovf;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] m_acc = '0;
  logic          m_sticky = 1'b0;
  logic          rnd_done = 1'b0;

  vedic_mac_pipe #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Handshakes are sampled on the falling edge; they complete on the next rising edge.
  always @(negedge clk) begin : monitor
    exp_t           e;
    logic [2*W-1:0] prod;
    logic [AW:0]    sum;
    if (rst_n && ena) begin
      if (out_valid && out_ready) begin
        checks++;
        pops++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got result=%0d ovf=%b, want no output", result, overflow);
        end else begin
          e = sb.pop_front();
          if (result !== e.res || overflow !== e.ovf) begin
            errors++;
            $display("FAIL sb_result: got result=%0d ovf=%b, want result=%0d ovf=%b",
                     result, overflow, e.res, e.ovf);
          end
        end
      end
      if (in_valid && in_ready) begin
        prod = (2*W)'(a) * (2*W)'(b);
        if (!mode) begin
          e.res = AW'(prod);
          e.ovf = m_sticky;
        end else if (acc_clr) begin
          m_acc    = AW'(prod);
          m_sticky = 1'b0;
          e.res    = m_acc;
          e.ovf    = m_sticky;
        end else begin
          sum      = {1'b0, m_acc} + (AW+1)'(prod);
          m_acc    = sum[AW-1:0];
          m_sticky = m_sticky | sum[AW];
          e.res    = m_acc;
          e.ovf    = m_sticky;
        end
        sb.push_back(e);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one transaction and return 1 time unit after the edge that accepts it.
  task automatic send(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                      input logic op_mode, input logic op_clr);
    int n;
    logic rdy;
    n = 0;
    a = op_a; b = op_b; mode = op_mode; acc_clr = op_clr; in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want 1", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: got pending=%0d out_valid=%b, want 0 and 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (result !== '0) begin
      errors++; $display("FAIL reset_result: got %0d want 0", result);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b want 0", overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    ena = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ena_in_ready: got %b want 0", in_ready);
    end
    ena = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_full();
    logic [W-1:0] blist[12] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd15, 8'd16,
                               8'd85, 8'd127, 8'd128, 8'd170, 8'd254, 8'd255};
    out_ready = 1'b1;
    send(8'd255, 8'd255, 1'b0, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mul_latency_early: got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 20'd65025 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mul_255x255: got valid=%b result=%0d ovf=%b, want 1 65025 0",
               out_valid, result, overflow);
    end
    drain();
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 12; j++) begin
        send(i[W-1:0], blist[j], 1'b0, 1'b0);
      end
    end
    drain();
  endtask

  task automatic test_mac();
    send(8'd10, 8'd20, 1'b1, 1'b1);
    send(8'd30, 8'd40, 1'b1, 1'b0);
    send(8'd3,  8'd3,  1'b0, 1'b0);
    send(8'd5,  8'd6,  1'b1, 1'b0);
    drain();
    checks++;
    if (result !== 20'd1430 || overflow !== 1'b0) begin
      errors++; $display("FAIL mac_final: got %0d ovf=%b want 1430 ovf=0", result, overflow);
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] opa[3] = '{8'd11, 8'd22, 8'd33};
    logic [W-1:0] opb[3] = '{8'd7, 8'd8, 8'd9};
    logic         rdy;
    logic [AW-1:0] held;
    int idx;
    int pops0;
    idx   = 0;
    pops0 = pops;
    out_ready = 1'b0;
    a = opa[0]; b = opb[0]; mode = 1'b0; acc_clr = 1'b0; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        idx++;
        if (idx < 3) begin
          a = opa[idx]; b = opb[idx];
        end
      end
    end
    checks++;
    if (idx !== 2) begin
      errors++; $display("FAIL bp_accepts: got %0d want 2", idx);
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_stall: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    held = result;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (result !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: got result=%0d in_ready=%b want %0d 0", result, in_ready, held);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(opa[2], opb[2], 1'b0, 1'b0);
    drain();
    checks++;
    if (pops - pops0 !== 3) begin
      errors++; $display("FAIL bp_count: got %0d outputs want 3", pops - pops0);
    end
  endtask

  task automatic test_overflow();
    send(8'd255, 8'd255, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) send(8'd255, 8'd255, 1'b1, 1'b0);
    drain();
    checks++;
    if (result !== 20'd56849 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_17th: got %0d ovf=%b want 56849 ovf=1", result, overflow);
    end
    send(8'd1, 8'd1, 1'b1, 1'b0);
    send(8'd2, 8'd2, 1'b0, 1'b0);
    drain();
    checks++;
    if (result !== 20'd4 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky_mul: got %0d ovf=%b want 4 ovf=1", result, overflow);
    end
    send(8'd1, 8'd1, 1'b1, 1'b1);
    drain();
    checks++;
    if (result !== 20'd1 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %0d ovf=%b want 1 ovf=0", result, overflow);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(8'd10, 8'd10, 1'b1, 1'b0);
    send(8'd20, 8'd20, 1'b1, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_full: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: got valid=%b result=%0d ovf=%b want 0 0 0",
               out_valid, result, overflow);
    end
    sb.delete();
    m_acc    = '0;
    m_sticky = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'd5, 8'd5, 1'b1, 1'b0);
    drain();
    checks++;
    if (result !== 20'd25 || overflow !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: got %0d ovf=%b want 25 ovf=0", result, overflow);
    end
  endtask

  task automatic test_enable_freeze();
    logic [AW-1:0] held;
    int pops0;
    pops0 = pops;
    out_ready = 1'b1;
    send(8'd12, 8'd13, 1'b0, 1'b0);
    ena = 1'b0;
    a = 8'd7; b = 8'd9; mode = 1'b0; acc_clr = 1'b0; in_valid = 1'b1;
    held = result;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== held) begin
        errors++;
        $display("FAIL freeze: got in_ready=%b out_valid=%b result=%0d want 0 0 %0d",
                 in_ready, out_valid, result, held);
      end
    end
    @(posedge clk); #1;
    ena = 1'b1;
    send(8'd7, 8'd9, 1'b0, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 20'd156) begin
      errors++; $display("FAIL freeze_resume: got valid=%b result=%0d want 1 156", out_valid, result);
    end
    drain();
    checks++;
    if (result !== 20'd63 || pops - pops0 !== 2) begin
      errors++;
      $display("FAIL freeze_final: got result=%0d outputs=%0d want 63 2", result, pops - pops0);
    end
  endtask

  task automatic test_random();
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        rnd_done = 1'b1;
      end
    join
    drain();
  endtask

  initial begin
    test_reset();
    test_mul_full();
    test_mac();
    test_back_pressure();
    test_overflow();
    test_reset_mid();
    test_enable_freeze();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
